pipe_ctl: RTL and testbench
===========================

// Module: pipe_ctl
// PURPOSE
//  Parametrised pipeline-control engine for the core top level. Generates per-stage valid,
//  allow_in and register-load enables for an N-stage in-order pipeline, plus RAW-hazard
//  interlock (destination scoreboard) and branch flush. The datapath stages and inter-stage
//  registers stay outside; each stage reports its own "over" and receives its load enable.
// PARAMETERS
//  STAGES     5  number of pipeline stages; stage 0 = fetch, STAGES-1 = writeback (>=3)
//  ADDR_W     5  register-address width; address 0 is hardwired zero and never hazards
//  ISSUE_STG  1  index of the operand-read stage that is checked and stalled (1..STAGES-2)
// PORTS
//  clk_i          in   1             clock
//  rst_n_i        in   1             synchronous reset, active low
//  stage_over_i   in   STAGES        per-stage work done this cycle (from datapath)
//  stage_valid_o  out  STAGES        stage holds a live instruction
//  stage_allow_o  out  STAGES        stage accepts a new instruction this cycle
//  stage_load_o   out  STAGES        enable for stage i input register ([0] = PC advance)
//  src1_use_i     in   1             issue-stage instruction reads src1
//  src1_addr_i    in   ADDR_W        src1 register address
//  src2_use_i     in   1             issue-stage instruction reads src2
//  src2_addr_i    in   ADDR_W        src2 register address
//  dest_we_i      in   1             issue-stage instruction writes a register
//  dest_addr_i    in   ADDR_W        its destination address
//  flush_i        in   1             kill stages 1..flush_stg_i (branch redirect)
//  flush_stg_i    in   $clog2(STAGES)  youngest-to-oldest kill boundary
//  hazard_o       out  1             issue stage stalled by RAW hazard
//  retire_o       out  1             valid[STAGES-1] & over_eff[STAGES-1]
//  perf_stall_o   out  32            stall-cycle counter (PIPE_CTL_PERF_EN)
//  perf_retire_o  out  32            retired-instruction counter (PIPE_CTL_PERF_EN)
// BEHAVIOUR
//  - Reset (rst_n_i=0 at clk edge): all valid=0, dest scoreboard cleared, counters=0;
//    combinational outputs therefore read hazard_o=0, retire_o=0, load_o[i>0]=0.
//  - valid[0] becomes 1 the cycle after reset release and stays 1 (fetch never idles).
//  - over_eff[i] = valid[i] & stage_over_i[i] & ~(i==ISSUE_STG & hazard_o).
//  - allow[i] = ~valid[i] | (over_eff[i] & allow[i+1]); allow[STAGES-1] = ~valid | over_eff.
//  - allow[0] = over_eff[0] & allow[1]; load[0] = allow[0].
//  - load[i>0] = allow[i] & over_eff[i-1] & ~kill[i-1]; on allow[i]: valid[i] <= load[i].
//  - Latency: 1 cycle per stage when all over=1; first retire STAGES cycles after release.
//  - Scoreboard: dest_r[k], we_r[k] for k>ISSUE_STG; shift on load[k] from dest_addr_i/
//    dest_we_i (k=ISSUE_STG+1) or dest_r[k-1]; live only while valid[k].
//  - hazard_o = valid[ISSUE] & OR over k>ISSUE of (valid[k] & we_r[k] & dest_r[k]!=0 &
//    ((src1_use_i & src1_addr_i==dest_r[k]) | (src2_use_i & src2_addr_i==dest_r[k]))).
//  - Flush: kill[i]=flush_i & (i>=1) & (i<=flush_stg_i); killed stages clear valid next edge
//    regardless of allow; stage flush_stg_i+1 receives a bubble. flush_stg_i>STAGES-2 is
//    clamped to STAGES-2. Stage 0 is not cleared (PC redirect is external).
//  - Flush and hazard same cycle: flush wins; issue stage emptied, no stall carried.
//  - Stalled stage holds valid and its upstream register (load=0); downstream drains.
//  - Reset mid-operation: everything cleared in one edge; no partial state survives.
// CONFIGURATION
//  PIPE_CTL_PERF_EN defined: perf_stall_o increments each cycle hazard_o=1, perf_retire_o
//  each cycle retire_o=1; both wrap at 2^32, cleared by reset.
//  Undefined: counters not built, perf_stall_o/perf_retire_o tied to 32'd0.
// STRUCTURE
//  Shared package/header common.vh: RegAddrBusW (=ADDR_W default), stage-index constants
//  STG_IF..STG_WB, PipeStagesDef. One sub-module: pipe_ctl_sb (scoreboard + hazard compare),
//  instantiated once; valid/allow/load chain stays in pipe_ctl via generate loop.
// TESTING
//  1 rst_n_i=0 3 cyc, all over=1 -> valid=0, hazard_o=0, perf=0; release -> valid=00001,
//    then 00011,... 11111 after 5 cyc; retire_o=1 from cycle 5 every cycle.
//  2 Steady stream, stage_over_i[3]=0 for 3 cyc -> allow[0..3]=0, valid[0..3] held,
//    valid[4] drops to 0 next cycle; resumes with no lost/duplicated instruction.
//  3 Writer r5 in EX, reader src1=r5 at ID -> hazard_o=1 for 3 cyc (EX,MEM,WB), load[2]=0,
//    then advances; perf_stall_o=3.
//  4 Writer r0, reader src1=r0 -> hazard_o=0; src1_use_i=0 with matching addr -> no stall.
//  5 flush_i=1, flush_stg_i=1 during a hazard -> valid[1]=0 next edge, hazard_o=0,
//    valid[2]=0 (bubble); flush_stg_i=7 behaves as 3.
//  6 Reset asserted mid-stall -> all valid and scoreboard cleared next edge, counters 0.

Source files
------------

// File: rtl/pipe_ctl_pkg.sv
// Shared constants for the pipeline-control engine: stage indices,
// default pipeline depth and register-address width.
package pipe_ctl_pkg;

    localparam int PipeStagesDef = 5;
    localparam int RegAddrBusW   = 5;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

endpackage

// File: rtl/pipe_ctl_sb.sv
// Destination scoreboard for the stages past issue, plus the RAW compare
// against the issue-stage source operands.
module pipe_ctl_sb
    import pipe_ctl_pkg::*;
#(
    parameter int STAGES    = PipeStagesDef,
    parameter int ADDR_W    = RegAddrBusW,
    parameter int ISSUE_STG = STG_ID
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [STAGES-1:ISSUE_STG]     valid,
    input  logic [STAGES-1:ISSUE_STG+1]   load,
    input  logic                          src1_use,
    input  logic [ADDR_W-1:0]             src1_addr,
    input  logic                          src2_use,
    input  logic [ADDR_W-1:0]             src2_addr,
    input  logic                          dest_we,
    input  logic [ADDR_W-1:0]             dest_addr,
    output logic                          hazard
);

    logic [ADDR_W-1:0]             dest_r [STAGES-1:ISSUE_STG+1];
    logic [STAGES-1:ISSUE_STG+1]   we_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_r <= '0;
            for (int k = ISSUE_STG + 1; k < STAGES; k++) begin
                dest_r[k] <= '0;
            end
        end else begin
            if (load[ISSUE_STG+1]) begin
                dest_r[ISSUE_STG+1] <= dest_addr;
                we_r[ISSUE_STG+1]   <= dest_we;
            end
            for (int k = ISSUE_STG + 2; k < STAGES; k++) begin
                if (load[k]) begin
                    dest_r[k] <= dest_r[k-1];
                    we_r[k]   <= we_r[k-1];
                end
            end
        end
    end

    // Entries only count while their stage still holds a live instruction.
    always_comb begin
        hazard = 1'b0;
        for (int k = ISSUE_STG + 1; k < STAGES; k++) begin
            if (valid[k] && we_r[k] && (dest_r[k] != '0) &&
                ((src1_use && (src1_addr == dest_r[k])) ||
                 (src2_use && (src2_addr == dest_r[k])))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & valid[ISSUE_STG];
    end

endmodule

// File: rtl/pipe_ctl.sv
// N-stage in-order pipeline control: valid/allow/load chain, RAW interlock,
// branch flush. Optional perf counters built when PIPE_CTL_PERF_EN is defined.
module pipe_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int STAGES    = PipeStagesDef,
    parameter int ADDR_W    = RegAddrBusW,
    parameter int ISSUE_STG = STG_ID
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [STAGES-1:0]           stage_over_i,
    output logic [STAGES-1:0]           stage_valid_o,
    output logic [STAGES-1:0]           stage_allow_o,
    output logic [STAGES-1:0]           stage_load_o,
    input  logic                        src1_use_i,
    input  logic [ADDR_W-1:0]           src1_addr_i,
    input  logic                        src2_use_i,
    input  logic [ADDR_W-1:0]           src2_addr_i,
    input  logic                        dest_we_i,
    input  logic [ADDR_W-1:0]           dest_addr_i,
    input  logic                        flush_i,
    input  logic [$clog2(STAGES)-1:0]   flush_stg_i,
    output logic                        hazard_o,
    output logic                        retire_o,
    output logic [31:0]                 perf_stall_o,
    output logic [31:0]                 perf_retire_o
);

    localparam int FW = $clog2(STAGES);
    localparam logic [FW-1:0] MAX_KILL = FW'(STAGES - 2);

    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] over_eff;
    logic [STAGES-1:0] allow;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] kill;
    logic [FW-1:0]     kill_stg;
    logic              hazard_raw;
    logic              hazard;

    assign kill_stg = (flush_stg_i > MAX_KILL) ? MAX_KILL : flush_stg_i;

    pipe_ctl_sb #(
        .STAGES    (STAGES),
        .ADDR_W    (ADDR_W),
        .ISSUE_STG (ISSUE_STG)
    ) u_sb (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .valid     (valid[STAGES-1:ISSUE_STG]),
        .load      (load[STAGES-1:ISSUE_STG+1]),
        .src1_use  (src1_use_i),
        .src1_addr (src1_addr_i),
        .src2_use  (src2_use_i),
        .src2_addr (src2_addr_i),
        .dest_we   (dest_we_i),
        .dest_addr (dest_addr_i),
        .hazard    (hazard_raw)
    );

    // A flushed issue stage is emptied anyway, so its stall is dropped.
    always_comb begin
        kill = '0;
        for (int i = 1; i < STAGES; i++) begin
            kill[i] = flush_i && (FW'(i) <= kill_stg);
        end
        hazard = hazard_raw & ~kill[ISSUE_STG];
        over_eff = valid & stage_over_i;
        over_eff[ISSUE_STG] = over_eff[ISSUE_STG] & ~hazard;
        allow = '0;
        allow[STAGES-1] = ~valid[STAGES-1] | over_eff[STAGES-1];
        for (int i = STAGES - 2; i >= 1; i--) begin
            allow[i] = ~valid[i] | (over_eff[i] & allow[i+1]);
        end
        allow[0] = over_eff[0] & allow[1];
        load = '0;
        load[0] = allow[0];
        for (int i = 1; i < STAGES; i++) begin
            load[i] = allow[i] & over_eff[i-1] & ~kill[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid <= '0;
        end else begin
            valid[0] <= 1'b1;
            for (int i = 1; i < STAGES; i++) begin
                if (kill[i]) begin
                    valid[i] <= 1'b0;
                end else if (allow[i]) begin
                    valid[i] <= load[i];
                end
            end
        end
    end

    assign stage_valid_o = valid;
    assign stage_allow_o = allow;
    assign stage_load_o  = load;
    assign hazard_o      = hazard;
    assign retire_o      = over_eff[STAGES-1];

`ifdef PIPE_CTL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] retire_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (hazard) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (over_eff[STAGES-1]) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_o  = stall_cnt;
    assign perf_retire_o = retire_cnt;
`else
    assign perf_stall_o  = 32'd0;
    assign perf_retire_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed bench for pipe_ctl (5 stages, issue at ID): reset fill, stall,
// RAW interlock, r0 and use-bit masking, flush with clamp, reset mid-stall.
module tb_pipe_ctl;
    import pipe_ctl_pkg::*;

`ifdef PIPE_CTL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [4:0]  over;
    logic [4:0]  valid;
    logic [4:0]  allow;
    logic [4:0]  load;
    logic        src1_use;
    logic [4:0]  src1_addr;
    logic        src2_use;
    logic [4:0]  src2_addr;
    logic        dest_we;
    logic [4:0]  dest_addr;
    logic        flush;
    logic [2:0]  flush_stg;
    logic        hazard;
    logic        retire;
    logic [31:0] perf_stall;
    logic [31:0] perf_retire;

    int errors = 0;
    int checks = 0;

    pipe_ctl dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .stage_over_i  (over),
        .stage_valid_o (valid),
        .stage_allow_o (allow),
        .stage_load_o  (load),
        .src1_use_i    (src1_use),
        .src1_addr_i   (src1_addr),
        .src2_use_i    (src2_use),
        .src2_addr_i   (src2_addr),
        .dest_we_i     (dest_we),
        .dest_addr_i   (dest_addr),
        .flush_i       (flush),
        .flush_stg_i   (flush_stg),
        .hazard_o      (hazard),
        .retire_o      (retire),
        .perf_stall_o  (perf_stall),
        .perf_retire_o (perf_retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded bound");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (valid !== 5'b00000) begin errors++; $display("FAIL rst_valid: got %b want 00000", valid); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rst_hazard: got %b want 0", hazard); end
        checks++; if (retire !== 1'b0) begin errors++; $display("FAIL rst_retire: got %b want 0", retire); end
        checks++; if (load[4:1] !== 4'b0000) begin errors++; $display("FAIL rst_load: got %b want 0000", load[4:1]); end
        checks++; if (perf_stall !== 32'd0 || perf_retire !== 32'd0) begin
            errors++; $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_stall, perf_retire);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            logic [4:0] exp_v;
            exp_v = 5'((1 << k) - 1);
            step();
            checks++; if (valid !== exp_v) begin errors++; $display("FAIL fill_valid%0d: got %b want %b", k, valid, exp_v); end
            checks++; if (retire !== (k == 5)) begin errors++; $display("FAIL fill_retire%0d: got %b want %b", k, retire, (k == 5)); end
        end
        repeat (3) begin
            step();
            checks++; if (retire !== 1'b1) begin errors++; $display("FAIL stream_retire: got %b want 1", retire); end
        end
        checks++; if (perf_retire !== (PERF ? 32'd3 : 32'd0)) begin
            errors++; $display("FAIL perf_retire_fill: got %0d want %0d", perf_retire, (PERF ? 3 : 0));
        end
    endtask

    task automatic test_stall();
        over = 5'b10111;
        #1;
        checks++; if (allow !== 5'b10000) begin errors++; $display("FAIL stall_allow: got %b want 10000", allow); end
        checks++; if (valid !== 5'b11111) begin errors++; $display("FAIL stall_valid0: got %b want 11111", valid); end
        repeat (3) begin
            step();
            checks++; if (valid !== 5'b01111) begin errors++; $display("FAIL stall_valid: got %b want 01111", valid); end
            checks++; if (retire !== 1'b0) begin errors++; $display("FAIL stall_retire: got %b want 0", retire); end
        end
        over = 5'b11111;
        #1;
        checks++; if (allow !== 5'b11111) begin errors++; $display("FAIL resume_allow: got %b want 11111", allow); end
        step();
        checks++; if (valid !== 5'b11111) begin errors++; $display("FAIL resume_valid: got %b want 11111", valid); end
        checks++; if (retire !== 1'b1) begin errors++; $display("FAIL resume_retire: got %b want 1", retire); end
    endtask

    task automatic test_hazard();
        dest_we = 1'b1; dest_addr = 5'd5;
        step();
        dest_we = 1'b0; src1_use = 1'b1; src1_addr = 5'd5;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_ex: got %b want 1", hazard); end
        checks++; if (load[2] !== 1'b0) begin errors++; $display("FAIL haz_load2: got %b want 0", load[2]); end
        checks++; if (allow[1:0] !== 2'b00) begin errors++; $display("FAIL haz_allow: got %b want 00", allow[1:0]); end
        step();
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_mem: got %b want 1", hazard); end
        checks++; if (valid !== 5'b11011) begin errors++; $display("FAIL haz_valid_mem: got %b want 11011", valid); end
        step();
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_wb: got %b want 1", hazard); end
        checks++; if (valid !== 5'b10011) begin errors++; $display("FAIL haz_valid_wb: got %b want 10011", valid); end
        step();
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL haz_clear: got %b want 0", hazard); end
        checks++; if (load[2] !== 1'b1) begin errors++; $display("FAIL haz_release: got %b want 1", load[2]); end
        checks++; if (perf_stall !== (PERF ? 32'd3 : 32'd0)) begin
            errors++; $display("FAIL perf_stall: got %0d want %0d", perf_stall, (PERF ? 3 : 0));
        end
        src1_use = 1'b0;
        step();
    endtask

    task automatic test_masking();
        int n;
        dest_we = 1'b1; dest_addr = 5'd0;
        step();
        dest_we = 1'b0; src1_use = 1'b1; src1_addr = 5'd0;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL r0_hazard: got %b want 0", hazard); end
        step();
        src1_use = 1'b0; dest_we = 1'b1; dest_addr = 5'd7;
        step();
        dest_we = 1'b0; src1_addr = 5'd7; src2_use = 1'b0; src2_addr = 5'd7;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL nouse_hazard: got %b want 0", hazard); end
        step();
        dest_we = 1'b1; dest_addr = 5'd9;
        step();
        dest_we = 1'b0; src2_use = 1'b1; src2_addr = 5'd9;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL src2_hazard: got %b want 1", hazard); end
        n = 0;
        while (hazard === 1'b1 && n < 8) begin
            step();
            n++;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL src2_stall_len: got %0d want 3", n); end
        src2_use = 1'b0;
        step();
    endtask

    task automatic test_flush();
        dest_we = 1'b1; dest_addr = 5'd5;
        step();
        dest_we = 1'b0; src1_use = 1'b1; src1_addr = 5'd5;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL flush_pre_haz: got %b want 1", hazard); end
        flush = 1'b1; flush_stg = 3'd1;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL flush_haz_mask: got %b want 0", hazard); end
        step();
        flush = 1'b0; src1_use = 1'b0;
        checks++; if (valid[3:0] !== 4'b1001) begin errors++; $display("FAIL flush1_valid: got %b want 1001", valid[3:0]); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL flush1_haz: got %b want 0", hazard); end
        repeat (6) step();
        checks++; if (valid !== 5'b11111) begin errors++; $display("FAIL refill1: got %b want 11111", valid); end
        flush = 1'b1; flush_stg = 3'd2;
        step();
        flush = 1'b0;
        checks++; if (valid !== 5'b10001) begin errors++; $display("FAIL flush2_valid: got %b want 10001", valid); end
        repeat (6) step();
        checks++; if (valid !== 5'b11111) begin errors++; $display("FAIL refill2: got %b want 11111", valid); end
        flush = 1'b1; flush_stg = 3'd7;
        step();
        flush = 1'b0;
        checks++; if (valid !== 5'b00001) begin errors++; $display("FAIL flush7_clamp: got %b want 00001", valid); end
        repeat (6) step();
    endtask

    task automatic test_reset_mid_stall();
        dest_we = 1'b1; dest_addr = 5'd5;
        step();
        dest_we = 1'b0; src1_use = 1'b1; src1_addr = 5'd5;
        step();
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL mid_haz: got %b want 1", hazard); end
        rst_n = 1'b0;
        step();
        checks++; if (valid !== 5'b00000) begin errors++; $display("FAIL mid_rst_valid: got %b want 00000", valid); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL mid_rst_haz: got %b want 0", hazard); end
        checks++; if (perf_stall !== 32'd0 || perf_retire !== 32'd0) begin
            errors++; $display("FAIL mid_rst_perf: got %0d/%0d want 0/0", perf_stall, perf_retire);
        end
        rst_n = 1'b1;
        repeat (5) step();
        checks++; if (valid !== 5'b11111) begin errors++; $display("FAIL mid_refill: got %b want 11111", valid); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL mid_sb_clear: got %b want 0", hazard); end
        src1_use = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; over = 5'b11111;
        src1_use = 1'b0; src1_addr = '0;
        src2_use = 1'b0; src2_addr = '0;
        dest_we = 1'b0; dest_addr = '0;
        flush = 1'b0; flush_stg = '0;
        test_reset();
        test_stall();
        test_hazard();
        test_masking();
        test_flush();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
